// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// class/func codes and the ALU op constants the controller drives.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_IEXEC  = 4'd3,
      S_REXEC  = 4'd4,
      S_BRANCH = 4'd5,
      S_JUMP   = 4'd6,
      S_MEMRD  = 4'd7,
      S_MEMWR  = 4'd8,
      S_ALUWB  = 4'd9,
      S_MEMWB  = 4'd10,
      S_LI     = 4'd11,
      S_LUI    = 4'd12,
      S_IMMWB  = 4'd13,
      S_TRAP   = 4'd15
   } state_t;

   localparam logic [1:0] CLASS_JUMP   = 2'b00;
   localparam logic [1:0] CLASS_REG    = 2'b01;
   localparam logic [1:0] CLASS_BRANCH = 2'b10;
   localparam logic [1:0] CLASS_IMM    = 2'b11;

   localparam logic [3:0] FUNC_LI   = 4'b1001;
   localparam logic [3:0] FUNC_LUI  = 4'b1010;
   localparam logic [3:0] FUNC_LW   = 4'b1011;
   localparam logic [3:0] FUNC_SW   = 4'b1100;
   localparam logic [3:0] FUNC_LWI  = 4'b1101;
   localparam logic [3:0] FUNC_SWI  = 4'b1110;
   localparam logic [3:0] FUNC_TRAP = 4'b1111;

   localparam logic [3:0] ALU_PASS = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0010;

   // States that stall on the memory handshake
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: DECODE-state successor and load/store
// classification taken from the top six IR bits.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
   output state_t             dec_next,
   output logic               is_load,
   output logic               is_store
);

   logic [1:0] cls;
   logic [3:0] func;
   logic [INSTR_W-7:0] unused_low_bits;

   assign cls             = instr[INSTR_W-1 -: 2];
   assign func            = instr[INSTR_W-3 -: 4];
   assign unused_low_bits = instr[INSTR_W-7:0];

   assign is_load  = (cls == CLASS_IMM) && ((func == FUNC_LW) || (func == FUNC_LWI));
   assign is_store = (cls == CLASS_IMM) && ((func == FUNC_SW) || (func == FUNC_SWI));

   always_comb begin
      dec_next = S_IEXEC;
      if ({cls, func} == 6'd0) begin
         dec_next = S_FETCH;
      end else begin
         case (cls)
            CLASS_JUMP:   dec_next = S_JUMP;
            CLASS_REG:    dec_next = S_REXEC;
            CLASS_BRANCH: dec_next = S_BRANCH;
            default: begin
               case (func)
                  FUNC_LI:   dec_next = S_LI;
                  FUNC_LUI:  dec_next = S_LUI;
                  FUNC_LW, FUNC_LWI, FUNC_SW, FUNC_SWI: dec_next = S_MEMADR;
                  FUNC_TRAP: dec_next = S_TRAP;
                  default:   dec_next = S_IEXEC;
               endcase
            end
         endcase
      end
   end

endmodule

// File: rtl/mc_controller_gen2.sv
// Multicycle datapath controller. Define MC_CTRL_MEM_TIMEOUT_EN to add a
// memory-wait watchdog that traps after 2**TO_W-1 consecutive stalled cycles.
module mc_controller_gen2
   import mc_ctrl_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int TO_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic               reg_write,
   output logic               lui,
   output logic               swb,
   output logic [1:0]         pc_source,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         branch_type,
   output logic [3:0]         alu_op,
   output logic [3:0]         state,
   output logic               fault
);

   state_t     state_reg;
   state_t     dec_next;
   logic       is_load;
   logic       is_store;
   logic       timeout;
   logic [1:0] cls;
   logic [3:0] func;

   assign cls  = instr[INSTR_W-1 -: 2];
   assign func = instr[INSTR_W-3 -: 4];

   mc_ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
      .instr    (instr),
      .dec_next (dec_next),
      .is_load  (is_load),
      .is_store (is_store)
   );

`ifdef MC_CTRL_MEM_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LIMIT = '1;
   logic [TO_W-1:0] to_cnt_reg;

   // Fires on the stalled cycle that would bring the run length to TO_LIMIT
   assign timeout = is_wait_state(state_reg) && !mem_ready && (to_cnt_reg == TO_LIMIT - 1'b1);

   always_ff @(posedge clk) begin
      if (reset)
         to_cnt_reg <= '0;
      else if (is_wait_state(state_reg) && !mem_ready && !timeout)
         to_cnt_reg <= to_cnt_reg + 1'b1;
      else
         to_cnt_reg <= '0;
   end
`else
   logic [TO_W-1:0] unused_to_w;
   assign unused_to_w = '0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
      end else begin
         case (state_reg)
            S_FETCH:  if (timeout) state_reg <= S_TRAP; else if (mem_ready) state_reg <= S_DECODE;
            S_DECODE: state_reg <= dec_next;
            S_MEMADR: begin
               if (is_load)       state_reg <= S_MEMRD;
               else if (is_store) state_reg <= S_MEMWR;
               else               state_reg <= S_FETCH;
            end
            S_IEXEC, S_REXEC: state_reg <= S_ALUWB;
            S_MEMRD:  if (timeout) state_reg <= S_TRAP; else if (mem_ready) state_reg <= S_MEMWB;
            S_MEMWR:  if (timeout) state_reg <= S_TRAP; else if (mem_ready) state_reg <= S_FETCH;
            S_LI, S_LUI: state_reg <= S_IMMWB;
            S_TRAP:   state_reg <= S_TRAP;
            default:  state_reg <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      reg_write   = 1'b0;
      lui         = 1'b0;
      swb         = 1'b0;
      pc_source   = 2'b00;
      alu_src_b   = 2'b00;
      branch_type = 2'b00;
      alu_op      = ALU_PASS;
      case (state_reg)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            swb       = (cls == CLASS_BRANCH);
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            swb       = is_store;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = func;
         end
         S_REXEC: begin
            alu_src_a = 1'b1;
            alu_op    = func;
         end
         S_BRANCH: begin
            pc_write    = 1'b1;
            branch_type = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_MEMRD: mem_read = 1'b1;
         S_MEMWR: begin
            mem_write = 1'b1;
            swb       = 1'b1;
         end
         S_ALUWB, S_IMMWB: reg_write = 1'b1;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_LI: begin
            alu_src_b = 2'b11;
            alu_op    = func;
         end
         S_LUI: begin
            alu_src_b = 2'b11;
            alu_op    = func;
            lui       = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = state_reg;
   assign fault = (state_reg == S_TRAP);

endmodule

// File: tb/tb_mc_controller_gen2.sv
// Directed self-checking bench for mc_controller_gen2; expected state traces
// and strobe values are hand-derived per instruction class.
module tb_mc_controller_gen2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        mem_ready;
   logic        pc_write, ir_write, mem_read, mem_write, mem_to_reg;
   logic        alu_src_a, reg_write, lui, swb;
   logic [1:0]  pc_source, alu_src_b, branch_type;
   logic [3:0]  alu_op;
   logic [3:0]  state;
   logic        fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_controller_gen2 #(.INSTR_W(32), .TO_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_to_reg  (mem_to_reg),
      .alu_src_a   (alu_src_a),
      .reg_write   (reg_write),
      .lui         (lui),
      .swb         (swb),
      .pc_source   (pc_source),
      .alu_src_b   (alu_src_b),
      .branch_type (branch_type),
      .alu_op      (alu_op),
      .state       (state),
      .fault       (fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance one cycle, sample on the falling edge, check the state code
   task automatic cyc(input string tag, input logic [3:0] exp_state);
      @(negedge clk);
      $display("step %-12s instr=%08h ready=%0b state=%0d", tag, instr, mem_ready, state);
      chk(tag, {28'd0, state}, {28'd0, exp_state});
   endtask

   initial begin
      reset     = 1'b1;
      instr     = 32'h0;
      mem_ready = 1'b1;
      @(negedge clk);
      cyc("reset", 4'd0);
      chk("rst_fault", fault, 0);
      chk("rst_mem_read", mem_read, 1);
      chk("rst_ir_write", ir_write, 1);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_alu_src_b", alu_src_b, 2'b01);
      chk("rst_alu_op", alu_op, 4'b0010);
      mem_ready = 1'b0;
      #1;
      chk("fetch_irw_wait", ir_write, 0);
      chk("fetch_pcw_wait", pc_write, 0);

      // R-type
      reset = 1'b0; mem_ready = 1'b1; instr = 32'h4400_0000;
      cyc("r_decode", 4'd1);
      chk("r_dec_srcb", alu_src_b, 2'b11);
      chk("r_dec_aluop", alu_op, 4'b0000);
      cyc("r_rexec", 4'd4);
      chk("r_aluop", alu_op, 4'b0001);
      chk("r_srcb", alu_src_b, 2'b00);
      chk("r_srca", alu_src_a, 1);
      chk("r_regw_exec", reg_write, 0);
      cyc("r_aluwb", 4'd9);
      chk("r_regw_wb", reg_write, 1);
      cyc("r_fetch", 4'd0);

      // Load with two stalled MEMRD cycles
      instr = 32'hF400_0010;
      cyc("lw_decode", 4'd1);
      cyc("lw_memadr", 4'd2);
      chk("lw_adr_srcb", alu_src_b, 2'b10);
      chk("lw_adr_swb", swb, 0);
      mem_ready = 1'b0;
      cyc("lw_memrd1", 4'd7);
      chk("lw_memread", mem_read, 1);
      cyc("lw_memrd2", 4'd7);
      cyc("lw_memrd3", 4'd7);
      mem_ready = 1'b1;
      cyc("lw_memwb", 4'd10);
      chk("lw_mem_to_reg", mem_to_reg, 1);
      chk("lw_regw", reg_write, 1);
      cyc("lw_fetch", 4'd0);

      // Two FETCH wait cycles, then a store
      mem_ready = 1'b0; instr = 32'hF000_0000;
      cyc("fetch_wait1", 4'd0);
      cyc("fetch_wait2", 4'd0);
      mem_ready = 1'b1;
      cyc("sw_decode", 4'd1);
      chk("sw_dec_swb", swb, 0);
      cyc("sw_memadr", 4'd2);
      chk("sw_adr_swb", swb, 1);
      chk("sw_adr_aluop", alu_op, 4'b0010);
      cyc("sw_memwr", 4'd8);
      chk("sw_memwrite", mem_write, 1);
      chk("sw_swb", swb, 1);
      cyc("sw_fetch", 4'd0);

      // Branch
      instr = 32'h8000_0000;
      cyc("br_decode", 4'd1);
      chk("br_dec_swb", swb, 1);
      cyc("br_branch", 4'd5);
      chk("br_pcw", pc_write, 1);
      chk("br_type", branch_type, 2'b01);
      cyc("br_fetch", 4'd0);

      // Jump
      instr = 32'h0400_0000;
      cyc("j_decode", 4'd1);
      cyc("j_jump", 4'd6);
      chk("j_pcsrc", pc_source, 2'b10);
      chk("j_pcw", pc_write, 1);
      cyc("j_fetch", 4'd0);

      // NOP
      instr = 32'h0000_0000;
      cyc("nop_decode", 4'd1);
      cyc("nop_fetch", 4'd0);

      // LI and LUI
      instr = 32'hE400_0000;
      cyc("li_decode", 4'd1);
      cyc("li_li", 4'd11);
      chk("li_aluop", alu_op, 4'b1001);
      chk("li_srcb", alu_src_b, 2'b11);
      chk("li_lui", lui, 0);
      cyc("li_immwb", 4'd13);
      chk("li_regw", reg_write, 1);
      cyc("li_fetch", 4'd0);
      instr = 32'hE800_0000;
      cyc("lui_decode", 4'd1);
      cyc("lui_lui", 4'd12);
      chk("lui_lui", lui, 1);
      chk("lui_aluop", alu_op, 4'b1010);
      cyc("lui_immwb", 4'd13);
      cyc("lui_fetch", 4'd0);

      // I-type
      instr = 32'hC400_0000;
      cyc("i_decode", 4'd1);
      cyc("i_iexec", 4'd3);
      chk("i_srcb", alu_src_b, 2'b10);
      chk("i_aluop", alu_op, 4'b0001);
      cyc("i_aluwb", 4'd9);
      cyc("i_fetch", 4'd0);

      // Reset while stalled in MEMWR
      instr = 32'hF000_0000;
      cyc("rw_decode", 4'd1);
      cyc("rw_memadr", 4'd2);
      mem_ready = 1'b0;
      cyc("rw_memwr", 4'd8);
      chk("rw_memwrite", mem_write, 1);
      reset = 1'b1;
      cyc("rw_reset", 4'd0);
      chk("rw_memwrite_clr", mem_write, 0);

      // Trap is sticky until reset
      reset = 1'b0; mem_ready = 1'b1; instr = 32'hFC00_0000;
      cyc("trap_decode", 4'd1);
      cyc("trap_enter", 4'd15);
      chk("trap_fault", fault, 1);
      repeat (19) @(negedge clk);
      cyc("trap_hold", 4'd15);
      chk("trap_hold_fault", fault, 1);
      chk("trap_memread", mem_read, 0);
      chk("trap_pcw", pc_write, 0);
      reset = 1'b1;
      cyc("trap_reset", 4'd0);
      chk("trap_fault_clr", fault, 0);

      // Unbroken memory stall in FETCH
      reset = 1'b0; mem_ready = 1'b0; instr = 32'h0;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
      repeat (13) @(negedge clk);
      cyc("to_pre", 4'd0);
      cyc("to_trap", 4'd15);
      chk("to_fault", fault, 1);
      reset = 1'b1;
      cyc("to_reset", 4'd0);
      reset = 1'b0;
`else
      repeat (99) @(negedge clk);
      cyc("stall_100", 4'd0);
      chk("stall_irw", ir_write, 0);
      chk("stall_fault", fault, 0);
`endif
      mem_ready = 1'b1;
      cyc("recover", 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_controller_gen2.md
MC_CONTROLLER_GEN2 -- requirements
Module: mc_controller_gen2

Interface
REQ-001 SHALL have parameter INSTR_W, default 32: instruction width; class = instr[INSTR_W-1 -: 2], func = instr[INSTR_W-3 -: 4].
REQ-002 SHALL have parameter TO_W, default 4: memory-timeout counter width; limit = 2**TO_W-1 cycles.
REQ-003 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset, synchronous, active-high).
REQ-004 SHALL have port instr (in, INSTR_W): current IR contents.
REQ-005 SHALL have port mem_ready (in, 1): memory completes the current access this cycle.
REQ-006 SHALL have ports pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src_a, reg_write, lui, swb (out, 1 each): datapath strobes.
REQ-007 SHALL have ports pc_source, alu_src_b, branch_type (out, 2 each) and alu_op (out, 4): datapath selects.
REQ-008 SHALL have ports state (out, 4): current state; fault (out, 1): sticky trap flag.

Function
REQ-009 SHALL be a single-register FSM; all outputs decode from state, except the FETCH strobes (REQ-011), which also use mem_ready. Every output not listed for a state is 0.
REQ-010 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, IEXEC=3, REXEC=4, BRANCH=5, JUMP=6, MEMRD=7, MEMWR=8, ALUWB=9, MEMWB=10, LI=11, LUI=12, IMMWB=13, TRAP=15.
REQ-011 FETCH: mem_read=1, alu_src_b=01, alu_op=0010, ir_write=pc_write=mem_ready; stay until mem_ready=1, then go to DECODE.
REQ-012 DECODE: alu_src_b=11, alu_op=0000, swb=1 when class=10. Next state:
 - instr[INSTR_W-1 -: 6]==0 (NOP) -> FETCH
 - class 00 -> JUMP; class 01 -> REXEC; class 10 -> BRANCH
 - class 11: func 1001 -> LI; 1010 -> LUI; 1011/1101/1100/1110 -> MEMADR; 1111 -> TRAP; else -> IEXEC
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0010; swb=1 for store. Next: func 1011/1101 -> MEMRD; 1100/1110 -> MEMWR.
REQ-014 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=func; -> ALUWB. REXEC: same with alu_src_b=00; -> ALUWB.
REQ-015 BRANCH: pc_write=1, branch_type=01; -> FETCH. JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-016 MEMRD: mem_read=1; hold until mem_ready, then -> MEMWB. MEMWR: mem_write=1, swb=1; hold until mem_ready, then -> FETCH.
REQ-017 ALUWB: reg_write=1 -> FETCH. MEMWB: reg_write=1, mem_to_reg=1 -> FETCH.
REQ-018 LI: alu_src_b=11, alu_op=func -> IMMWB. LUI: same plus lui=1 -> IMMWB. IMMWB: reg_write=1 -> FETCH.
REQ-019 TRAP: all strobes 0, fault=1; stays in TRAP until reset.
REQ-020 Latency at zero wait: NOP 2, branch/jump 3, R/I/LI/LUI 4, store 4, load 5 cycles; each mem_ready=0 cycle adds 1.
REQ-021 The 4-bit state encodings 14 and any unlisted code SHALL go to FETCH on the next clock.

Reset
REQ-022 reset=1 at a clock edge SHALL force state=FETCH and fault=0 and clear the timeout counter, regardless of state, including mid-wait or TRAP. Outputs then follow FETCH decode.

Configuration
REQ-023 With MC_CTRL_MEM_TIMEOUT_EN defined, a TO_W-bit counter SHALL count consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR. It clears on mem_ready=1 or on leaving the state. At 2**TO_W-1, the next state SHALL be TRAP.
REQ-024 Without MC_CTRL_MEM_TIMEOUT_EN, no counter SHALL exist and wait states are unbounded.

Structure
REQ-025 Package mc_ctrl_pkg SHALL hold the state encodings, class codes (00/01/10/11), func codes (LI, LUI, LW, LWI, SW, SWI, TRAP) and ALU op constants (ADD=0010, PASS=0000).
REQ-026 Sub-module mc_ctrl_decode SHALL be purely combinational: maps instr to DECODE next-state and load/store flags.

Verification
REQ-027 R-type instr=0x44000000 with mem_ready tied 1 -> states 0,1,4,9,0; reg_write=1 only in state 9; alu_op=0001 in state 4.
REQ-028 LW instr=0xF4000010 with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,7,7,7,10,0; mem_to_reg=1 in state 10.
REQ-029 instr=0xFC000000 -> DECODE then TRAP with fault=1, held for 20 cycles; reset pulse -> state 0, fault 0.
REQ-030 With MC_CTRL_MEM_TIMEOUT_EN and TO_W=4, mem_ready=0 held in FETCH -> TRAP after 15 wait cycles; without the macro -> still in FETCH after 100 cycles.
REQ-031 reset asserted in MEMWR with mem_ready=0 -> next state 0, mem_write=0 on the following cycle.
